// File: rtl/logic_unit_pipe.sv
// Purpose: 3-operand bitwise logic unit (8 ops) with reduction flags and a saturating delivered-result counter.
// Latency: 2 registered stages; input accepted at edge k appears on out_valid/y from edge k+1.
// Backpressure: valid/ready; stages hold while stalled, in_ready depends only on pipeline state and out_ready.
module logic_unit_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               y_any,
    output logic               y_all,
    output logic               y_par,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] txn_count
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [2:0]       op;
    } s1_t;

    s1_t              s1_dat;
    logic             s1_vld;
    logic             s2_load;
    logic             out_hs;
    logic [WIDTH-1:0] y_nxt;

    // S2 takes S1 whenever its own slot is empty or being drained this cycle.
    assign s2_load  = s1_vld && (!out_valid || out_ready);
    // S1 can accept when empty or when its contents move into S2 this cycle.
    assign in_ready = !s1_vld || s2_load;
    assign out_hs   = out_valid && out_ready;

    // Stage 1: capture operands and op on an input handshake; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat <= {a, b, c, op};
            end
        end
    end

    // Bitwise operation selected by the op captured in stage 1.
    always_comb begin
        y_nxt = '0;
        case (s1_dat.op)
            3'd0:    y_nxt = s1_dat.a & s1_dat.b & s1_dat.c;
            3'd1:    y_nxt = s1_dat.a | s1_dat.b | s1_dat.c;
            3'd2:    y_nxt = s1_dat.a ^ s1_dat.b ^ s1_dat.c;
            3'd3:    y_nxt = ~(s1_dat.a & s1_dat.b & s1_dat.c);
            3'd4:    y_nxt = ~(s1_dat.a | s1_dat.b | s1_dat.c);
            3'd5:    y_nxt = ~(s1_dat.a ^ s1_dat.b ^ s1_dat.c);
            3'd6:    y_nxt = (s1_dat.a & s1_dat.b) | (s1_dat.b & s1_dat.c) | (s1_dat.a & s1_dat.c);
            3'd7:    y_nxt = (s1_dat.c & s1_dat.b) | (~s1_dat.c & s1_dat.a);
            default: y_nxt = '0;
        endcase
    end

    // Stage 2: register result and reductions; drop valid on a handshake with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_any     <= 1'b0;
            y_all     <= 1'b0;
            y_par     <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            y         <= y_nxt;
            y_any     <= |y_nxt;
            y_all     <= &y_nxt;
            y_par     <= ^y_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-result counter: saturates at all-ones, clear has priority over a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (cnt_clr) begin
            txn_count <= '0;
        end else if (out_hs && (txn_count != {COUNT_W{1'b1}})) begin
            txn_count <= txn_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Purpose: self-checking bench for logic_unit_pipe with directed scenarios and a random scoreboard run.
// Latency: drives inputs 1 time unit after posedge, observes at negedge and 1 unit after posedge.
// Backpressure: out_ready is driven directly by the scenarios; expected in_ready comes from occupancy.
module tb_logic_unit_pipe;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r_y;
        logic         r_any;
        logic         r_all;
        logic         r_par;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready, cnt_clr;
    logic [W-1:0] a, b, c;
    logic [2:0]   op;
    logic         in_ready, out_valid, y_any, y_all, y_par;
    logic [W-1:0] y;
    logic [15:0]  txn_count;
    logic         in_ready2, out_valid2, y_any2, y_all2, y_par2;
    logic [W-1:0] y2;
    logic [1:0]   txn_count2;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_any(y_any), .y_all(y_all), .y_par(y_par),
        .cnt_clr(cnt_clr), .txn_count(txn_count)
    );

    // Narrow-counter copy sharing all stimulus, used for saturation.
    logic_unit_pipe #(.WIDTH(W), .COUNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .c(c), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .y_any(y_any2), .y_all(y_all2), .y_par(y_par2),
        .cnt_clr(cnt_clr), .txn_count(txn_count2)
    );

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t o_res, exp_res;
    bit   i_hs, o_hs, rdy_obs, ov_obs, missing;
    logic [W-1:0] y_obs;

    // Reference: each bit from the count of ones among a/b/c (or the select for MUX).
    function automatic res_t ref_model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                       input logic [W-1:0] cc, input logic [2:0] oo);
        res_t r;
        int   n;
        int   s;
        logic v;
        r = '0;
        n = 0;
        for (int i = 0; i < W; i++) begin
            s = int'(aa[i]) + int'(bb[i]) + int'(cc[i]);
            case (oo)
                3'd0: v = (s == 3);
                3'd1: v = (s > 0);
                3'd2: v = (s % 2 == 1);
                3'd3: v = (s != 3);
                3'd4: v = (s == 0);
                3'd5: v = (s % 2 == 0);
                3'd6: v = (s >= 2);
                default: v = cc[i] ? bb[i] : aa[i];
            endcase
            r.r_y[i] = v;
            n += int'(v);
        end
        r.r_any = (n > 0);
        r.r_all = (n == W);
        r.r_par = (n % 2 == 1);
        return r;
    endfunction

    // One clock: observe handshakes at negedge, update scoreboard, return 1 unit after posedge.
    task automatic tick();
        @(negedge clk);
        rdy_obs = in_ready;
        ov_obs  = out_valid;
        y_obs   = y;
        i_hs    = rst_n && in_valid && in_ready;
        o_hs    = rst_n && out_valid && out_ready;
        if (o_hs) begin
            o_res = {y, y_any, y_all, y_par};
            if (exp_q.size() == 0) missing = 1'b1;
            else exp_res = exp_q.pop_front();
        end
        if (i_hs) exp_q.push_back(ref_model(a, b, c, op));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        a = '0; b = '0; c = '0; op = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || y !== 8'h00 || {y_any, y_all, y_par} !== 3'b000) begin
            errors++;
            $display("FAIL reset_out: out_valid=%b y=%h flags=%b, want 0 00 000", out_valid, y, {y_any, y_all, y_par});
        end
        checks++;
        if (txn_count !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", txn_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (rdy_obs !== 1'b1 || ov_obs !== 1'b0) begin
            errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", rdy_obs, ov_obs);
        end
    endtask

    task automatic test_truth();
        logic [W-1:0] tbl [8];
        tbl = '{8'h80, 8'hFE, 8'h96, 8'h7F, 8'h01, 8'h69, 8'hE8, 8'hD8};
        out_ready = 1'b1;
        a = 8'hF0; b = 8'hCC; c = 8'hAA;
        for (int j = 0; j < 9; j++) begin
            in_valid = (j < 8);
            op = 3'(j);
            tick();
            if (j == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL truth_latency: out_valid=%b after first edge, want 0", out_valid);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || y !== tbl[j-1]) begin
                    errors++; $display("FAIL truth_op%0d: out_valid=%b y=%h want 1 %h", j-1, out_valid, y, tbl[j-1]);
                end
                if (j == 1) begin
                    checks++;
                    if (y_par !== 1'b1) begin
                        errors++; $display("FAIL truth_par_and: got %b want 1", y_par);
                    end
                end
                if (j == 2) begin
                    checks++;
                    if (y_all !== 1'b0) begin
                        errors++; $display("FAIL truth_all_or: got %b want 0", y_all);
                    end
                end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL truth_drain: out_valid=%b pending=%0d want 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_reductions();
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'd1; a = 8'hFF; b = 8'hFF; c = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || y !== 8'hFF || {y_any, y_all, y_par} !== 3'b110) begin
            errors++;
            $display("FAIL red_ones: v=%b y=%h flags=%b want 1 ff 110", out_valid, y, {y_any, y_all, y_par});
        end
        in_valid = 1'b1; op = 3'd0; a = 8'h00; b = 8'($urandom); c = 8'($urandom);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h00 || y_any !== 1'b0 || y_all !== 1'b0) begin
            errors++;
            $display("FAIL red_zero: v=%b y=%h any=%b all=%b want 1 00 0 0", out_valid, y, y_any, y_all);
        end
        tick();
    endtask

    task automatic test_counter();
        int sent;
        int del;
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (txn_count !== 16'd0) begin
            errors++; $display("FAIL cnt_clear: got %0d want 0", txn_count);
        end
        sent = 0; del = 0;
        for (int cyc = 0; cyc < 20 && del < 5; cyc++) begin
            in_valid = (sent < 5);
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); op = 3'($urandom);
            tick();
            if (i_hs) sent++;
            if (o_hs) del++;
        end
        in_valid = 1'b0;
        checks++;
        if (txn_count !== 16'd5 || txn_count2 !== 2'd3) begin
            errors++; $display("FAIL cnt_sat: wide=%0d narrow=%0d want 5 3", txn_count, txn_count2);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (o_hs !== 1'b1 || txn_count !== 16'd0 || txn_count2 !== 2'd0) begin
            errors++;
            $display("FAIL cnt_clr_hs: hs=%b wide=%0d narrow=%0d want 1 0 0", o_hs, txn_count, txn_count2);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] va [5], vb [5], vc [5];
        logic [2:0]   vo [5];
        logic [W-1:0] y_hold;
        int acc;
        int del;
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            va[i] = 8'($urandom); vb[i] = 8'($urandom); vc[i] = 8'($urandom); vo[i] = 3'($urandom);
        end
        acc = 0; del = 0; y_hold = '0;
        for (int cyc = 0; cyc < 40 && del < 5; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (acc < 5);
            if (acc < 5) begin
                a = va[acc]; b = vb[acc]; c = vc[acc]; op = vo[acc];
            end
            tick();
            if (i_hs) acc++;
            if (o_hs) begin
                del++;
                checks++;
                if (o_res !== exp_res) begin
                    errors++; $display("FAIL bp_data%0d: got %h want %h", del, o_res, exp_res);
                end
            end
            if (cyc == 1) y_hold = y;
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (rdy_obs !== 1'b0) begin
                    errors++; $display("FAIL bp_full_rdy: cycle %0d in_ready=%b want 0", cyc, rdy_obs);
                end
            end
            if (cyc == 3) begin
                checks++;
                if (acc != 2 || out_valid !== 1'b1 || y !== y_hold) begin
                    errors++;
                    $display("FAIL bp_stall: accepted=%0d v=%b y=%h want 2 1 %h", acc, out_valid, y, y_hold);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (del != 5 || txn_count !== 16'd5) begin
            errors++; $display("FAIL bp_total: delivered=%0d count=%0d want 5 5", del, txn_count);
        end
    endtask

    task automatic test_reset_mid();
        res_t first;
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); op = 3'($urandom);
        tick(); tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_full: v=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 8'h00 || txn_count !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: v=%b y=%h cnt=%0d rdy=%b want 0 00 0 1", out_valid, y, txn_count, in_ready);
        end
        exp_q.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (ov_obs !== 1'b0 || rdy_obs !== 1'b1) begin
            errors++; $display("FAIL mid_after: v=%b rdy=%b want 0 1", ov_obs, rdy_obs);
        end
        in_valid = 1'b1;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); op = 3'($urandom);
        first = ref_model(a, b, c, op);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_lat1: v=%b after one edge, want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || {y, y_any, y_all, y_par} !== first) begin
            errors++; $display("FAIL mid_lat2: v=%b res=%h want 1 %h", out_valid, {y, y_any, y_all, y_par}, first);
        end
        tick();
    endtask

    task automatic test_random();
        int   acc;
        int   del;
        int   occ;
        bit   prev_stall;
        logic [W-1:0] prev_y;
        bit   exp_rdy;
        acc = 0; del = 0; prev_stall = 1'b0; prev_y = '0; missing = 1'b0;
        in_valid = 1'b0; exp_q.delete();
        for (int cyc = 0; cyc < 10000 && (acc < 1000 || del < acc); cyc++) begin
            if (!in_valid || i_hs) begin
                a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); op = 3'($urandom);
            end
            in_valid  = (acc < 1000) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            occ = exp_q.size();
            exp_rdy = !(occ == 2 && !out_ready);
            tick();
            checks++;
            if (rdy_obs !== exp_rdy) begin
                errors++; $display("FAIL rnd_rdy: cycle %0d in_ready=%b want %b", cyc, rdy_obs, exp_rdy);
            end
            if (prev_stall) begin
                checks++;
                if (ov_obs !== 1'b1 || y_obs !== prev_y) begin
                    errors++; $display("FAIL rnd_hold: cycle %0d v=%b y=%h want 1 %h", cyc, ov_obs, y_obs, prev_y);
                end
            end
            prev_stall = ov_obs && !out_ready;
            prev_y = y_obs;
            if (i_hs) acc++;
            if (o_hs) begin
                del++;
                checks++;
                if (o_res !== exp_res) begin
                    errors++; $display("FAIL rnd_data%0d: got %h want %h", del, o_res, exp_res);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc != 1000 || del != 1000 || missing || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_total: accepted=%0d delivered=%0d extra=%b left=%0d want 1000 1000 0 0",
                     acc, del, missing, exp_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_truth();
        test_reductions();
        test_counter();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
